wb_tgt_mem: RTL and testbench

//  Pipelined Wishbone target: word-addressed on-chip memory responding to one crossbar target port.

---
 rtl/wb_tgt_mem.sv | 165 ++++++++++++++++
 tb/tb_wb_tgt_mem.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_tgt_mem.sv
// Pipelined Wishbone target backed by a word-addressed on-chip memory.
// Fixed-latency in-order responses, optional periodic stall, err on out-of-range addresses.
module wb_tgt_mem #(
  parameter int ADR_WIDTH    = 16,
  parameter int DAT_WIDTH    = 16,
  parameter int SEL_WIDTH    = 2,
  parameter int TGWD_WIDTH   = 1,
  parameter int TGRD_WIDTH   = 1,
  parameter int MEM_AW       = 8,
  parameter int LATENCY      = 2,
  parameter int STALL_PERIOD = 0
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  sync_rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic                  lock_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic [ADR_WIDTH-1:0]  adr_i,
  input  logic [DAT_WIDTH-1:0]  dat_i,
  input  logic                  tga_i,
  input  logic                  tgc_i,
  input  logic [TGWD_WIDTH-1:0] tgd_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  rty_o,
  output logic                  stall_o,
  output logic [DAT_WIDTH-1:0]  dat_o,
  output logic [TGRD_WIDTH-1:0] tgd_o
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic                  err;
    logic                  we;
    logic [DAT_WIDTH-1:0]  rdata;
    logic [TGRD_WIDTH-1:0] rtag;
  } rsp_t;

  logic [DAT_WIDTH-1:0]  mem  [DEPTH];
  logic [TGWD_WIDTH-1:0] tmem [DEPTH];

  logic [MEM_AW-1:0]  idx;
  logic               oor;
  logic               acc;
  logic               resp;
  logic               stall_q;
  logic [LATENCY-1:0] vld_p;
  rsp_t               rsp_p [LATENCY];
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  state_t             state;
  rsp_t               last;

  function automatic logic [DAT_WIDTH-1:0] merge_bytes(
    input logic [DAT_WIDTH-1:0] cur,
    input logic [DAT_WIDTH-1:0] wr,
    input logic [SEL_WIDTH-1:0] sel
  );
    logic [DAT_WIDTH-1:0] res;
    res = cur;
    for (int k = 0; k < SEL_WIDTH; k++)
      if (sel[k]) res[k*8 +: 8] = wr[k*8 +: 8];
    return res;
  endfunction

  assign idx = adr_i[MEM_AW-1:0];

  generate
    if (MEM_AW < ADR_WIDTH) begin : g_oor
      assign oor = |adr_i[ADR_WIDTH-1:MEM_AW];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  assign acc     = cyc_i & stb_i & ~stall_o;
  assign last    = rsp_p[LATENCY-1];
  assign resp    = vld_p[LATENCY-1] & cyc_i;
  assign cnt_nxt = cnt + CNT_W'(acc) - CNT_W'(resp);

  // Accept edge: byte-lane write and read capture into stage 0
  always_ff @(posedge clk_i) begin
    if (acc & we_i & ~oor) begin
      mem[idx] <= merge_bytes(mem[idx], dat_i, sel_i);
      if (|sel_i) tmem[idx] <= tgd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    rsp_p[0].err   <= oor;
    rsp_p[0].we    <= we_i;
    rsp_p[0].rdata <= mem[idx];
    rsp_p[0].rtag  <= tmem[idx];
    for (int i = 1; i < LATENCY; i++) rsp_p[i] <= rsp_p[i-1];
  end

  // Control stages: valid shift, outstanding count and FSM; dropping cyc_i aborts everything in flight
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      vld_p <= '0;
      cnt   <= '0;
      state <= IDLE;
    end else if (sync_rst_i || !cyc_i) begin
      vld_p <= '0;
      cnt   <= '0;
      state <= IDLE;
    end else begin
      vld_p <= (vld_p << 1) | LATENCY'(acc);
      cnt   <= cnt_nxt;
      case (state)
        IDLE: if (acc) state <= BUSY;
        BUSY: if (cnt_nxt == '0 && !acc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      localparam int SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
      logic [SC_W-1:0] scnt;

      always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
          scnt    <= '0;
          stall_q <= 1'b0;
        end else if (sync_rst_i) begin
          scnt    <= '0;
          stall_q <= 1'b0;
        end else if (acc) begin
          if (scnt == SC_W'(STALL_PERIOD - 1)) begin
            scnt    <= '0;
            stall_q <= 1'b1;
          end else begin
            scnt    <= scnt + 1'b1;
            stall_q <= 1'b0;
          end
        end else begin
          stall_q <= 1'b0;
        end
      end
    end else begin : g_no_stall
      assign stall_q = 1'b0;
    end
  endgenerate

  assign stall_o = stall_q & cyc_i;
  assign ack_o   = resp & ~last.err;
  assign err_o   = resp & last.err;
  assign rty_o   = 1'b0;
  assign dat_o   = (ack_o & ~last.we) ? last.rdata : '0;
  assign tgd_o   = (ack_o & ~last.we) ? last.rtag  : '0;

  // Inputs accepted without effect; state is kept for observability only
  logic unused_ok;
  assign unused_ok = ^{lock_i, tga_i, tgc_i, state};

endmodule

// File: tb/tb_wb_tgt_mem.sv
// Bench for wb_tgt_mem: one LATENCY=2 no-stall instance (A) and one LATENCY=3 STALL_PERIOD=2 instance (B)
// sharing request fields; each has its own cyc/stb and an in-order expected-response queue.
module tb_wb_tgt_mem;

  logic        clk = 1'b0;
  logic        async_rst, sync_rst;
  logic        cyc_a, stb_a, cyc_b, stb_b;
  logic        we, lock, tga, tgc, tgd;
  logic [1:0]  sel;
  logic [15:0] adr, wdat;
  logic        ack_a, err_a, rty_a, stall_a, tgd_a;
  logic        ack_b, err_b, rty_b, stall_b, tgd_b;
  logic [15:0] dat_a, dat_b;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int ack_cnt_b = 0;

  typedef struct {
    logic        err;
    logic [15:0] dat;
    logic        tag;
    int          due;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [15:0] adr;
    logic [15:0] wd;
    logic        wt;
    logic        xerr;
    logic [15:0] xd;
    logic        xt;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb, tmp;
  vec_t tbl[20];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  wb_tgt_mem #(.LATENCY(2), .STALL_PERIOD(0)) dut_a (
    .clk_i(clk), .async_rst_i(async_rst), .sync_rst_i(sync_rst),
    .cyc_i(cyc_a), .stb_i(stb_a), .we_i(we), .lock_i(lock), .sel_i(sel),
    .adr_i(adr), .dat_i(wdat), .tga_i(tga), .tgc_i(tgc), .tgd_i(tgd),
    .ack_o(ack_a), .err_o(err_a), .rty_o(rty_a), .stall_o(stall_a),
    .dat_o(dat_a), .tgd_o(tgd_a)
  );

  wb_tgt_mem #(.LATENCY(3), .STALL_PERIOD(2)) dut_b (
    .clk_i(clk), .async_rst_i(async_rst), .sync_rst_i(sync_rst),
    .cyc_i(cyc_b), .stb_i(stb_b), .we_i(we), .lock_i(lock), .sel_i(sel),
    .adr_i(adr), .dat_i(wdat), .tga_i(tga), .tgc_i(tgc), .tgd_i(tgd),
    .ack_o(ack_b), .err_o(err_b), .rty_o(rty_b), .stall_o(stall_b),
    .dat_o(dat_b), .tgd_o(tgd_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] s, input logic [15:0] a,
                       input logic [15:0] d, input logic t);
    we = w; sel = s; adr = a; wdat = d; tgd = t;
  endtask

  task automatic push(input logic to_b, input logic e, input logic [15:0] d, input logic t);
    tmp.err = e; tmp.dat = d; tmp.tag = t;
    if (to_b) begin
      tmp.due = edge_cnt + 3;
      q_b.push_back(tmp);
    end else begin
      tmp.due = edge_cnt + 2;
      q_a.push_back(tmp);
    end
  endtask

  always @(negedge clk) begin
    if (ack_a || err_a) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_rsp", 64'({ack_a, err_a}), 64'(0));
      end else begin
        ea = q_a.pop_front();
        chk("a_rsp", 64'({ack_a, err_a, dat_a, tgd_a}), 64'({~ea.err, ea.err, ea.dat, ea.tag}));
        chk("a_latency", 64'(edge_cnt), 64'(ea.due));
      end
    end
  end

  always @(negedge clk) begin
    if (ack_b) ack_cnt_b++;
    if (ack_b || err_b) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_rsp", 64'({ack_b, err_b}), 64'(0));
      end else begin
        eb = q_b.pop_front();
        chk("b_rsp", 64'({ack_b, err_b, dat_b, tgd_b}), 64'({~eb.err, eb.err, eb.dat, eb.tag}));
        chk("b_latency", 64'(edge_cnt), 64'(eb.due));
      end
    end
  end

  initial begin
    int idx, accepts, ack_base;
    logic mstall, nstall;
    int mcnt;

    tbl[0]  = '{1'b1, 2'b11, 16'h0005, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 2'b11, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b1};
    tbl[2]  = '{1'b1, 2'b01, 16'h0005, 16'hABCD, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 2'b11, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h12CD, 1'b0};
    tbl[4]  = '{1'b1, 2'b11, 16'h0000, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[5]  = '{1'b1, 2'b11, 16'h0100, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b0};
    tbl[6]  = '{1'b0, 2'b11, 16'h0100, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
    tbl[7]  = '{1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h5A5A, 1'b1};
    tbl[8]  = '{1'b1, 2'b00, 16'h0005, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[9]  = '{1'b0, 2'b11, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h12CD, 1'b0};
    tbl[10] = '{1'b1, 2'b11, 16'h0010, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[11] = '{1'b1, 2'b10, 16'h0010, 16'h7700, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[12] = '{1'b0, 2'b11, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h7711, 1'b1};
    tbl[13] = '{1'b1, 2'b11, 16'h00FF, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[14] = '{1'b0, 2'b11, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1};
    tbl[15] = '{1'b0, 2'b11, 16'h8000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
    tbl[16] = '{1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h5A5A, 1'b1};
    tbl[17] = '{1'b0, 2'b11, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h12CD, 1'b0};
    tbl[18] = '{1'b0, 2'b11, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h7711, 1'b1};
    tbl[19] = '{1'b0, 2'b11, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1};

    async_rst = 1'b1; sync_rst = 1'b0;
    cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0;
    lock = 1'b0; tga = 1'b0; tgc = 1'b0;
    drive(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
    #2;
    chk("rst_a", 64'({ack_a, err_a, rty_a, stall_a, dat_a, tgd_a}), 64'(0));
    chk("rst_b", 64'({ack_b, err_b, rty_b, stall_b, dat_b, tgd_b}), 64'(0));
    repeat (2) @(negedge clk);
    async_rst = 1'b0;

    // Back-to-back table on A; lock/tags toggled to show they have no effect
    lock = 1'b1; tga = 1'b1; tgc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cyc_a = 1'b1; stb_a = 1'b1;
      drive(tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].wd, tbl[i].wt);
      chk("a_no_stall", 64'(stall_a), 64'(0));
      push(1'b0, tbl[i].xerr, tbl[i].xd, tbl[i].xt);
    end
    @(posedge clk); #1;
    stb_a = 1'b0; lock = 1'b0; tga = 1'b0; tgc = 1'b0;
    for (int n = 0; n < 12 && q_a.size() != 0; n++) @(posedge clk);
    chk("a_drain", 64'(q_a.size()), 64'(0));

    // Async reset with a response on the bus and more in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      stb_a = 1'b1;
      drive(1'b0, 2'b11, tbl[16+i].adr, 16'h0000, 1'b0);
      push(1'b0, 1'b0, tbl[16+i].xd, tbl[16+i].xt);
    end
    chk("a_ack_before_rst", 64'(ack_a), 64'(1));
    #1 async_rst = 1'b1;
    #1;
    chk("a_async_rst_out", 64'({ack_a, err_a, rty_a, stall_a, dat_a, tgd_a}), 64'(0));
    chk("b_async_rst_out", 64'({ack_b, err_b, rty_b, stall_b, dat_b, tgd_b}), 64'(0));
    cyc_a = 1'b0; stb_a = 1'b0;
    q_a.delete();
    #1 async_rst = 1'b0;

    // Memory contents survive reset
    @(posedge clk); #1;
    cyc_a = 1'b1; stb_a = 1'b1;
    drive(1'b0, 2'b11, 16'h0005, 16'h0000, 1'b0);
    push(1'b0, 1'b0, 16'h12CD, 1'b0);
    @(posedge clk); #1;
    stb_a = 1'b0;
    for (int n = 0; n < 8 && q_a.size() != 0; n++) @(posedge clk);
    chk("a_retention_drain", 64'(q_a.size()), 64'(0));
    cyc_a = 1'b0;

    // Abort on B: cyc dropped the cycle after accept, no response ever
    @(posedge clk); #1;
    cyc_b = 1'b1; stb_b = 1'b1;
    drive(1'b0, 2'b11, 16'h0005, 16'h0000, 1'b0);
    @(posedge clk); #1;
    cyc_b = 1'b0; stb_b = 1'b0;
    @(posedge clk); #1;
    cyc_b = 1'b1;
    for (int n = 0; n < 6; n++) begin
      chk("b_abort_quiet", 64'({ack_b, err_b}), 64'(0));
      @(posedge clk); #1;
    end
    chk("b_fsm_idle", 64'(dut_b.state), 64'(0));
    cyc_b = 1'b0;

    // Sync reset drops A's pending read
    @(posedge clk); #1;
    cyc_a = 1'b1; stb_a = 1'b1;
    drive(1'b0, 2'b11, 16'h0005, 16'h0000, 1'b0);
    @(posedge clk); #1;
    stb_a = 1'b0; sync_rst = 1'b1;
    @(posedge clk); #1;
    sync_rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk("a_sync_rst_out", 64'({ack_a, err_a, stall_a, dat_a, tgd_a}), 64'(0));
      @(posedge clk); #1;
    end
    cyc_a = 1'b0;

    // Continuous stb on B with STALL_PERIOD=2: 6 writes then 6 reads
    idx = 0; accepts = 0; mcnt = 0; nstall = 1'b0; mstall = 1'b0;
    ack_base = ack_cnt_b;
    for (int c = 0; c < 40 && idx < 12; c++) begin
      @(posedge clk); #1;
      mstall = nstall;
      cyc_b = 1'b1; stb_b = 1'b1;
      if (idx < 6)
        drive(1'b1, 2'b11, 16'h0020 + 16'(idx), 16'hC000 + 16'(idx * 16'h0111), 1'(idx & 1));
      else
        drive(1'b0, 2'b11, 16'h0020 + 16'(idx - 6), 16'h0000, 1'b0);
      chk("b_stall", 64'(stall_b), 64'(mstall));
      if (!mstall) begin
        if (idx < 6) push(1'b1, 1'b0, 16'h0000, 1'b0);
        else push(1'b1, 1'b0, 16'hC000 + 16'((idx - 6) * 16'h0111), 1'((idx - 6) & 1));
        accepts++;
        idx++;
        mcnt++;
        if (mcnt == 2) begin
          mcnt = 0;
          nstall = 1'b1;
        end else begin
          nstall = 1'b0;
        end
      end else begin
        nstall = 1'b0;
      end
    end
    @(posedge clk); #1;
    stb_b = 1'b0;
    for (int n = 0; n < 12 && q_b.size() != 0; n++) @(posedge clk);
    chk("b_drain", 64'(q_b.size()), 64'(0));
    chk("b_accepts", 64'(accepts), 64'(12));
    chk("b_ack_count", 64'(ack_cnt_b - ack_base), 64'(accepts));
    cyc_b = 1'b0;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
